// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-triggered interrupt controller with fixed-priority grant, IDLE/REQ/SERV handshake.
// Define INT_CTRL_SYNC_EN to pass irq_in through a two-flop synchronizer before edge detection.
module int_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic             INT,
  output logic [2:0]       int_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  localparam logic [3:0] A_PEND  = 4'h0;
  localparam logic [3:0] A_MASK  = 4'h4;
  localparam logic [3:0] A_CLAIM = 4'h8;
  localparam logic [3:0] A_EOI   = 4'hC;

  // Edge detection stays off until the history reflects real samples, so a
  // line already high when reset releases does not look like a new edge.
`ifdef INT_CTRL_SYNC_EN
  localparam logic [1:0] WARM = 2'd3;
  logic [N_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_SRC-1:0] irq_s;
  assign irq_s = sync2_q;
`else
  localparam logic [1:0] WARM = 2'd1;
  logic [N_SRC-1:0] irq_s;
  assign irq_s = irq_in;
`endif

  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_v, elig, wr_clr, ack_clr;
  logic [1:0]       warm_q, warm_d;
  state_t           state_q, state_d;
  logic             int_q, int_d;
  logic [2:0]       id_q, id_d, win;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];

  always_comb begin
`ifdef INT_CTRL_SYNC_EN
    sync1_d = irq_in;
    sync2_d = sync1_q;
`endif
    prev_d = irq_s;
    warm_d = (warm_q == WARM) ? warm_q : warm_q + 2'd1;
    edge_v = (warm_q == WARM) ? (irq_s & ~prev_q) : '0;
    elig   = pend_q & mask_q;
    win    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = 3'(i);
    end
    wr_clr  = (we && addr == A_PEND) ? wdata[N_SRC-1:0] : '0;
    mask_d  = (we && addr == A_MASK) ? wdata[N_SRC-1:0] : mask_q;
    ack_clr = '0;
    state_d = state_q;
    int_d   = int_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          int_d   = 1'b1;
          id_d    = win;
        end
      end
      REQ: begin
        // Losing the granted bit before the ack drops the request outright.
        if (!elig[id_q]) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end else if (int_ack) begin
          state_d       = SERV;
          int_d         = 1'b0;
          ack_clr[id_q] = 1'b1;
        end
      end
      SERV: begin
        if (we && addr == A_EOI) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
      end
    endcase
    // New edges are ORed in last so a same-cycle set beats any clear.
    pend_d = (pend_q & ~wr_clr & ~ack_clr) | edge_v;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
`ifdef INT_CTRL_SYNC_EN
      sync1_q <= '0;
      sync2_q <= '0;
`endif
      prev_q  <= '0;
      warm_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= IDLE;
      int_q   <= 1'b0;
      id_q    <= '0;
    end else begin
`ifdef INT_CTRL_SYNC_EN
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
`endif
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      int_q   <= int_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_PEND:  rdata[N_SRC-1:0] = pend_q;
      A_MASK:  rdata[N_SRC-1:0] = mask_q;
      A_CLAIM: rdata = {state_q == SERV, 28'b0, id_q};
      default: rdata = '0;
    endcase
  end

  assign INT    = int_q;
  assign int_id = id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - randomized and directed checks of int_ctrl against a behavioural model.
module tb_int_ctrl;
  localparam int N = 8;
`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk     = 1'b0;
  logic          RSTN    = 1'b0;
  logic [N-1:0]  irq_in  = '0;
  logic          we      = 1'b0;
  logic [3:0]    addr    = 4'h0;
  logic [31:0]   wdata   = '0;
  logic [31:0]   rdata;
  logic          int_ack = 1'b0;
  logic          INT;
  logic [2:0]    int_id;

  int_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .RSTN(RSTN), .irq_in(irq_in), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .int_ack(int_ack), .INT(INT), .int_id(int_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending/mask sets, whether a request is outstanding or in service, which source.
  bit [N-1:0] m_pend, m_mask;
  bit         m_int, m_serv;
  int         m_id;
  bit [N-1:0] hist[4];
  int         n_smp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h0:    return 32'(m_pend);
      4'h4:    return 32'(m_mask);
      4'h8:    return {m_serv, 28'b0, 3'(m_id)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_pend = '0; m_mask = '0; m_int = 1'b0; m_serv = 1'b0; m_id = 0; n_smp = 0;
    foreach (hist[i]) hist[i] = '0;
  endtask

  task automatic m_clock();
    bit [N-1:0] e, clr;
    int low;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = irq_in;
    if (n_smp < 8) n_smp++;
    e   = (n_smp - LAT - 1 >= 1) ? (hist[LAT] & ~hist[LAT+1]) : '0;
    clr = (we && addr == 4'h0) ? wdata[N-1:0] : '0;
    low = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) low = i;
    if (m_int) begin
      if (!(m_pend[m_id] && m_mask[m_id])) m_int = 1'b0;
      else if (int_ack) begin
        m_int = 1'b0; m_serv = 1'b1; clr[m_id] = 1'b1;
      end
    end else if (m_serv) begin
      if (we && addr == 4'hC) m_serv = 1'b0;
    end else if (low >= 0) begin
      m_int = 1'b1; m_id = low;
    end
    if (we && addr == 4'h4) m_mask = wdata[N-1:0];
    m_pend = (m_pend & ~clr) | e;
  endtask

  task automatic compare();
    chk("int", 32'(INT), 32'(m_int));
    chk("int_id", 32'(int_id), 32'(m_id));
    chk("rdata", rdata, m_read(addr));
  endtask

  task automatic step(input logic [N-1:0] irq, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic ack);
    @(negedge clk);
    irq_in = irq; we = w; addr = a; wdata = d; int_ack = ack;
    #1;
    compare();
    m_clock();
    @(posedge clk);
    #1;
    we = 1'b0; int_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // One-cycle pulse, then wait until the request should just have reached INT.
  task automatic pulse_wait(input logic [N-1:0] v);
    step(v, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("pulse_early_int", 32'(INT), 32'h0);
    idle(LAT + 1);
  endtask

  logic [31:0] v;
  logic [N-1:0] r_irq;
  logic         r_we, r_ack;
  logic [3:0]   r_addr;
  logic [31:0]  r_d;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_int", 32'(INT), 32'h0);
    chk("rst_id", 32'(int_id), 32'h0);
    rd(4'h0, v); chk("rst_pend", v, 32'h0);
    rd(4'h4, v); chk("rst_mask", v, 32'h0);
    rd(4'h8, v); chk("rst_claim", v, 32'h0);
    RSTN = 1'b1;
    idle(4);

    // Single source, ack then EOI.
    step('0, 1'b1, 4'h4, 32'h1, 1'b0);
    pulse_wait(8'h01);
    chk("t028_int", 32'(INT), 32'h1);
    chk("t028_id", 32'(int_id), 32'h0);
    chk("t028_model_int", 32'(m_int), 32'h1);
    step('0, 1'b0, 4'h0, 32'h0, 1'b1);
    chk("t028_int_ack", 32'(INT), 32'h0);
    rd(4'h0, v); chk("t028_pend", v, 32'h0);
    rd(4'h8, v); chk("t028_claim", v, 32'h8000_0000);
    chk("t028_model_claim", m_read(4'h8), 32'h8000_0000);
    step('0, 1'b1, 4'hC, 32'h0, 1'b0);

    // Two same-cycle edges: lower index first, then the other after EOI.
    step('0, 1'b1, 4'h4, 32'hFF, 1'b0);
    pulse_wait(8'h24);
    chk("t029_int", 32'(INT), 32'h1);
    chk("t029_id", 32'(int_id), 32'h2);
    step('0, 1'b0, 4'h0, 32'h0, 1'b1);
    step('0, 1'b1, 4'hC, 32'h0, 1'b0);
    chk("t029_int_eoi", 32'(INT), 32'h0);
    idle(1);
    chk("t029_int2", 32'(INT), 32'h1);
    chk("t029_id2", 32'(int_id), 32'h5);
    chk("t029_model_id2", 32'(m_id), 32'h5);
    step('0, 1'b0, 4'h0, 32'h0, 1'b1);
    step('0, 1'b1, 4'hC, 32'h0, 1'b0);

    // Masked source stays pending until unmasked.
    step('0, 1'b1, 4'h4, 32'h0, 1'b0);
    pulse_wait(8'h08);
    chk("t030_int_masked", 32'(INT), 32'h0);
    rd(4'h0, v); chk("t030_pend", v, 32'h08);
    step('0, 1'b1, 4'h4, 32'h08, 1'b0);
    idle(1);
    chk("t030_int", 32'(INT), 32'h1);
    chk("t030_id", 32'(int_id), 32'h3);
    step('0, 1'b0, 4'h0, 32'h0, 1'b1);
    step('0, 1'b1, 4'hC, 32'h0, 1'b0);

    // Software clear of the granted bit drops the request.
    step('0, 1'b1, 4'h4, 32'h02, 1'b0);
    pulse_wait(8'h02);
    chk("t031_int", 32'(INT), 32'h1);
    chk("t031_id", 32'(int_id), 32'h1);
    step('0, 1'b1, 4'h0, 32'h02, 1'b0);
    idle(1);
    chk("t031_int_drop", 32'(INT), 32'h0);
    rd(4'h0, v); chk("t031_pend", v, 32'h0);
    rd(4'h8, v); chk("t031_not_serv", v >> 31, 32'h0);

    // Same-cycle set and clear: set wins.
    step('0, 1'b1, 4'h4, 32'h0, 1'b0);
    pulse_wait(8'h10);
    for (int k = 0; k <= LAT; k++) step(8'h10, k == LAT, 4'h0, 32'h10, 1'b0);
    rd(4'h0, v); chk("t032_pend4", v & 32'h10, 32'h10);
    step('0, 1'b1, 4'h0, 32'h10, 1'b0);
    rd(4'h0, v); chk("t032_pend_clr", v, 32'h0);

    // Asynchronous reset while in service.
    step('0, 1'b1, 4'h4, 32'h01, 1'b0);
    pulse_wait(8'h01);
    step('0, 1'b0, 4'h0, 32'h0, 1'b1);
    rd(4'h8, v); chk("t033_serv", v, 32'h8000_0000);
    #2;
    RSTN = 1'b0;
    #1;
    chk("t033_int", 32'(INT), 32'h0);
    rd(4'h0, v); chk("t033_pend", v, 32'h0);
    rd(4'h4, v); chk("t033_mask", v, 32'h0);
    rd(4'h8, v); chk("t033_claim", v, 32'h0);
    m_reset();

    // A line already high at reset release must not request.
    irq_in = 8'h01;
    @(posedge clk);
    #1;
    RSTN = 1'b1;
    step(8'h01, 1'b1, 4'h4, 32'h01, 1'b0);
    for (int i = 0; i < 6; i++) step(8'h01, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("t026_int", 32'(INT), 32'h0);
    rd(4'h0, v); chk("t026_pend", v, 32'h0);
    idle(1);
    pulse_wait(8'h01);
    chk("t026_int_rearm", 32'(INT), 32'h1);
    step('0, 1'b0, 4'h0, 32'h0, 1'b1);
    step('0, 1'b1, 4'hC, 32'h0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      r_irq  = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      r_we   = ($urandom_range(0, 5) == 0);
      r_addr = 4'($urandom_range(0, 3)) << 2;
      r_d    = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom & $urandom);
      r_ack  = ($urandom_range(0, 2) == 0);
      step(r_irq, r_we, r_addr, r_d, r_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, default 8, is the number of interrupt sources (1..8).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 RSTN  input  1  asynchronous active-low reset.
REQ-004 irq_in  input  N_SRC  source request lines (counter0/1/2 outputs, button pulses); rising edge = request.
REQ-005 we  input  1  bus write strobe, one-cycle.
REQ-006 addr  input  4  bus byte address: 0x0 PEND, 0x4 MASK, 0x8 CLAIM, 0xC EOI.
REQ-007 wdata  input  32  bus write data.
REQ-008 rdata  output  32  bus read data, combinational from addr.
REQ-009 int_ack  input  1  CPU acknowledge pulse on interrupt entry.
REQ-010 INT  output  1  interrupt request to CPU, registered.
REQ-011 int_id  output  3  index of the granted source, registered.

Function
REQ-012 Edge detect: pending[i] is set one cycle after irq_in[i] is sampled high with the previous sample low; level-high alone never re-sets the bit.
REQ-013 Pending bits are set regardless of MASK; only pending & MASK is eligible to raise INT.
REQ-014 PEND write is write-1-to-clear; when a set and a clear hit the same bit in the same cycle, set wins.
REQ-015 MASK read/write, bits above N_SRC-1 read 0 and ignore writes.
REQ-016 Priority: lowest eligible index wins; fixed, no rotation.
REQ-017 FSM states IDLE, REQ, SERV.
REQ-018 IDLE -> REQ when any eligible bit exists; int_id latches the winner and INT goes high on that transition (INT asserts 2 cycles after the source edge).
REQ-019 REQ: INT held high, int_id frozen even if a higher-priority source arrives; int_ack -> SERV, clears pending[int_id], INT low next cycle.
REQ-020 REQ: if the granted bit is cleared by a PEND write or masked before int_ack, return to IDLE with INT low (spurious-drop).
REQ-021 SERV: INT stays low (no nesting); any write to EOI -> IDLE; re-arbitration possible the following cycle.
REQ-022 int_ack outside REQ is ignored; EOI write outside SERV is ignored.
REQ-023 CLAIM read returns {state==SERV, 28'b0, int_id}; reads have no side effects.
REQ-024 Edges arriving in SERV set pending normally and are served after EOI; no edge is lost unless cleared by software.

Reset
REQ-025 RSTN low asynchronously forces IDLE, pending=0, MASK=0, INT=0, int_id=0, edge-history=0; reset mid-service discards in-service state.
REQ-026 After RSTN release, an irq_in already high does not create a request until it falls and rises again.

Configuration
REQ-027 Macro INT_CTRL_SYNC_EN: defined -> each irq_in passes a two-flop synchronizer before edge detect, adding 2 cycles (INT asserts 4 cycles after the edge); undefined -> irq_in sampled directly, inputs must be clk-synchronous.

Verification
REQ-028 MASK=0x01, pulse irq_in[0] -> INT high 2 cycles later (4 with INT_CTRL_SYNC_EN), int_id=0; int_ack -> INT low, PEND=0x00, CLAIM=0x80000000.
REQ-029 MASK=0xFF, edges on irq_in[5] and irq_in[2] same cycle -> int_id=2; ack+EOI -> INT re-asserts with int_id=5.
REQ-030 MASK=0x00, edge on irq_in[3] -> PEND=0x08, INT stays 0; write MASK=0x08 -> INT high, int_id=3.
REQ-031 In REQ with int_id=1, write PEND=0x02 -> FSM IDLE, INT low, no ack needed.
REQ-032 Write PEND=0x10 in the same cycle irq_in[4] edge sets it -> PEND bit4 remains 1.
REQ-033 Assert RSTN low while in SERV -> INT=0, PEND=0, MASK=0 immediately, no clk edge required.
